sprite_rom_cache: RTL and testbench
===================================

// Module: sprite_rom_cache
// PURPOSE
// - Read cache between the sprite engine's ROM fetch port (sdr_addr/sdr_req/sdr_rdy, 64-bit data) and the SDRAM controller port.
// - Direct-mapped, one 64-bit line per entry. Repeated row fetches of the same sprite tile hit locally and free SDRAM bandwidth for the other layers.
// - Client-side protocol is identical to the SDRAM port, so the block drops in without changes to the sprite engine.
// PARAMETERS
// - INDEX_BITS  8   log2(number of lines); the default gives 256 x 64-bit lines.
// - ADDR_W      24  width of the word address, bits [ADDR_W:1].
// PORTS
// - CLK_96M      in   1   sole clock; the sprite engine's clock.
// - RESET_N      in   1   synchronous, active-low reset.
// - FLUSH        in   1   one-cycle pulse; invalidates all lines (ROM reload).
// - cl_addr      in   24  client word address [24:1]; [2:1] is always 0.
// - cl_req       in   1   one-cycle request pulse.
// - cl_rdy       out  1   high = idle or data valid; low while a request is in flight.
// - cl_data      out  64  returned line; held stable while cl_rdy=1.
// - mem_addr     out  24  SDRAM word address [24:1].
// - mem_req      out  1   one-cycle request pulse to SDRAM.
// - mem_rdy      in   1   SDRAM data valid.
// - mem_data     in   64  SDRAM read data.
// BEHAVIOUR
// - Address split: index = cl_addr[INDEX_BITS+2:3]; tag = cl_addr[24:INDEX_BITS+3].
// - Storage per line: valid bit in a flop vector; tag and data in dpramv.
// - Reset values: cl_rdy=1, cl_data=0, mem_req=0, mem_addr=0, state=IDLE, all valid bits=0.
// - IDLE:
//   - On cl_req: latch the address, read the tag/data RAM, drive cl_rdy=0 on the next cycle, go to LOOKUP.
//   - cl_req is accepted only in IDLE; a pulse in any other state is dropped.
// - LOOKUP (one cycle after the RAM read):
//   - Hit (valid & tag match): cl_data=RAM data, cl_rdy=1, return to IDLE.
//   - Hit latency: cl_req at cycle N gives cl_rdy=1 at N+2.
//   - Miss: mem_addr=latched address, mem_req=1 for one cycle, go to FILL.
// - FILL:
//   - mem_rdy is ignored on the first two cycles after the mem_req pulse (the controller drops rdy in that window).
//   - From the third cycle, the first cycle with mem_rdy=1:
//     - write mem_data and the tag into the RAM;
//     - set valid[index] unless a FLUSH arrived during this fill;
//     - cl_data=mem_data, cl_rdy=1, return to IDLE.
// - FLUSH:
//   - Clears every valid bit in the cycle it is seen.
//   - In LOOKUP it forces a miss.
//   - Never aborts a fill: data is still returned, but the line stays invalid.
//   - A FLUSH and a fill completion in the same cycle leave the line invalid.
// - cl_req and fill completion in the same cycle: impossible, because cl_rdy=0 until completion.
// - Reset mid-FILL:
//   - Return to IDLE and clear all valid bits. The outstanding mem_rdy is ignored because the state is no longer FILL.
//   - The client restarts on its next line (VE[0] toggle).
// - Back-to-back: cl_req in the same cycle that cl_rdy rises is accepted.
// - Tag/data RAM: single read port plus single write port, both on CLK_96M; no bypass needed, since a write and a read never coincide.
// STRUCTURE
// - m72_pkg gains:
//   - localparam SPRITE_CACHE_INDEX_BITS (the default for INDEX_BITS);
//   - typedef enum logic [1:0] {SC_IDLE, SC_LOOKUP, SC_FILL} sprite_cache_state_t.
// - Tag and data storage: two dpramv instances (widths 64 and tag width).
// - Valid vector and FSM sit in this module; no further sub-module.
// TESTING
// 1. Cold miss:
//    - Stimulus: after reset, cl_addr=24'h100040, cl_req.
//    - Response: mem_req with mem_addr=24'h100040 at N+2; model returns 64'hDEADBEEF01234567; cl_rdy=1 with that data one cycle after mem_rdy.
// 2. Hit:
//    - Stimulus: repeat test 1's address.
//    - Response: cl_rdy=1 at N+2 with 64'hDEADBEEF01234567; no mem_req.
// 3. Conflict:
//    - Stimulus: 24'h100040, then 24'h200040 (same index, different tag), then 24'h100040.
//    - Response: three misses, three mem_req pulses, correct data each time.
// 4. Flush:
//    - Stimulus: fill 24'h100040, pulse FLUSH, re-request.
//    - Response: miss with mem_req. Repeat with FLUSH mid-fill: data is returned but the next request still misses.
// 5. Reset mid-fill:
//    - Stimulus: RESET_N=0 in FILL, then a late mem_rdy.
//    - Response: cl_rdy=1 with no spurious write; the next request to that address misses.
// 6. Busy drop:
//    - Stimulus: second cl_req while in FILL.
//    - Response: ignored; exactly one mem_req; the first request completes normally.

Source files
------------

// File: rtl/sprite_rom_cache_pkg.sv
// Shared constants and types for the sprite ROM read cache.
package sprite_rom_cache_pkg;

    // Default geometry: 256 direct-mapped lines of 64 bits, 24-bit word address.
    localparam int unsigned SPRITE_CACHE_INDEX_BITS = 8;
    localparam int unsigned SPRITE_CACHE_ADDR_W     = 24;

    // Value of the fill wait counter from which mem_rdy is honoured. The SDRAM
    // controller drops rdy for two cycles after a request, so the pulse cycle
    // and the two following ones are ignored.
    localparam logic [1:0] FILL_RDY_WAIT = 2'd3;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_LOOKUP,
        SC_FILL
    } sprite_cache_state_t;

endpackage

// File: rtl/dpramv.sv
// Simple dual-port RAM: one synchronous write port and one registered read port
// on the same clock. No read/write bypass.
module dpramv #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output holds between reads.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sprite_rom_cache.sv
// Direct-mapped 64-bit line read cache between the sprite engine ROM fetch port
// and the SDRAM controller. Client and memory sides use the same req/rdy
// protocol, so the cache drops in transparently.
module sprite_rom_cache
    import sprite_rom_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = SPRITE_CACHE_INDEX_BITS,
    parameter int unsigned ADDR_W     = SPRITE_CACHE_ADDR_W
) (
    input  logic            CLK_96M,
    input  logic            RESET_N,
    input  logic            FLUSH,
    input  logic [ADDR_W:1] cl_addr,
    input  logic            cl_req,
    output logic            cl_rdy,
    output logic [63:0]     cl_data,
    output logic [ADDR_W:1] mem_addr,
    output logic            mem_req,
    input  logic            mem_rdy,
    input  logic [63:0]     mem_data
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;
    localparam int unsigned LINES = 1 << INDEX_BITS;

    sprite_cache_state_t   state_q;
    logic [ADDR_W:1]       addr_q;
    logic [1:0]            wait_q;
    logic                  flush_q;
    logic [LINES-1:0]      valid_q;

    logic [TAG_W-1:0]      tag_rd;
    logic [63:0]           data_rd;
    logic [INDEX_BITS-1:0] rd_index;
    logic [INDEX_BITS-1:0] line_index;
    logic [TAG_W-1:0]      line_tag;
    logic                  accept;
    logic                  hit;
    logic                  fill_done;
    logic                  ram_we;

    // Address split, hit detection and fill completion.
    always_comb begin
        rd_index   = cl_addr[INDEX_BITS+2:3];
        line_index = addr_q[INDEX_BITS+2:3];
        line_tag   = addr_q[ADDR_W:INDEX_BITS+3];
        accept     = (state_q == SC_IDLE) && cl_req;
        // A flush seen during lookup forces a miss.
        hit        = valid_q[line_index] && (tag_rd == line_tag) && !FLUSH;
        fill_done  = (state_q == SC_FILL) && (wait_q == FILL_RDY_WAIT) && mem_rdy;
        // Reset mid-fill must never commit the line.
        ram_we     = fill_done && RESET_N;
    end

    dpramv #(
        .DATA_W    (TAG_W),
        .ADDR_BITS (INDEX_BITS)
    ) u_tag_ram (
        .clk     (CLK_96M),
        .wr_en   (ram_we),
        .wr_addr (line_index),
        .wr_data (line_tag),
        .rd_en   (accept),
        .rd_addr (rd_index),
        .rd_data (tag_rd)
    );

    dpramv #(
        .DATA_W    (64),
        .ADDR_BITS (INDEX_BITS)
    ) u_data_ram (
        .clk     (CLK_96M),
        .wr_en   (ram_we),
        .wr_addr (line_index),
        .wr_data (mem_data),
        .rd_en   (accept),
        .rd_addr (rd_index),
        .rd_data (data_rd)
    );

    // Request FSM: accept in IDLE, compare in LOOKUP, wait for SDRAM in FILL.
    always_ff @(posedge CLK_96M) begin
        if (!RESET_N) begin
            state_q  <= SC_IDLE;
            addr_q   <= '0;
            wait_q   <= '0;
            flush_q  <= 1'b0;
            cl_rdy   <= 1'b1;
            cl_data  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_req <= 1'b0;
            case (state_q)
                SC_IDLE: begin
                    if (cl_req) begin
                        addr_q  <= cl_addr;
                        cl_rdy  <= 1'b0;
                        state_q <= SC_LOOKUP;
                    end
                end
                SC_LOOKUP: begin
                    if (hit) begin
                        cl_data <= data_rd;
                        cl_rdy  <= 1'b1;
                        state_q <= SC_IDLE;
                    end else begin
                        mem_addr <= addr_q;
                        mem_req  <= 1'b1;
                        wait_q   <= '0;
                        flush_q  <= 1'b0;
                        state_q  <= SC_FILL;
                    end
                end
                SC_FILL: begin
                    if (FLUSH) begin
                        flush_q <= 1'b1;
                    end
                    if (wait_q != FILL_RDY_WAIT) begin
                        wait_q <= wait_q + 2'd1;
                    end
                    if (fill_done) begin
                        cl_data <= mem_data;
                        cl_rdy  <= 1'b1;
                        state_q <= SC_IDLE;
                    end
                end
                default: begin
                    state_q <= SC_IDLE;
                end
            endcase
        end
    end

    // Valid bits: flush clears all; a fill sets its line unless a flush was seen
    // at any point during that fill (including its completion cycle).
    always_ff @(posedge CLK_96M) begin
        if (!RESET_N) begin
            valid_q <= '0;
        end else if (FLUSH) begin
            valid_q <= '0;
        end else if (fill_done && !flush_q) begin
            valid_q[line_index] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_rom_cache.sv
// Self-checking bench for sprite_rom_cache: directed table, corner sequences
// and randomized requests against an associative-array cache model.
module tb_sprite_rom_cache;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [24:1] cl_addr;
    logic        cl_req;
    logic        cl_rdy;
    logic [63:0] cl_data;
    logic [24:1] mem_addr;
    logic        mem_req;
    logic        mem_rdy;
    logic [63:0] mem_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sprite_rom_cache dut (
        .CLK_96M  (clk),
        .RESET_N  (rst_n),
        .FLUSH    (flush),
        .cl_addr  (cl_addr),
        .cl_req   (cl_req),
        .cl_rdy   (cl_rdy),
        .cl_data  (cl_data),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backing ROM contents.
    function automatic logic [63:0] mem_word(input logic [24:1] a);
        if (a == 24'h100040) return 64'hDEADBEEF01234567;
        return {a, 16'hC0DE, ~a};
    endfunction

    // SDRAM model: rdy is driven with junk for two cycles after each request,
    // then the real line arrives resp_delay cycles after the request pulse.
    int          resp_delay  = 3;
    int          req_count   = 0;
    int          req_cyc     = 0;
    logic [24:1] req_addr    = '0;
    bit          resp_active = 1'b0;
    int          resp_k      = 0;

    always @(negedge clk) begin
        mem_rdy = 1'b0;
        if (resp_active) begin
            resp_k++;
            if (resp_k < 3) begin
                mem_rdy  = 1'b1;
                mem_data = ~mem_word(req_addr);
            end else if (resp_k == resp_delay) begin
                mem_rdy     = 1'b1;
                mem_data    = mem_word(req_addr);
                resp_active = 1'b0;
            end
        end
        if (mem_req) begin
            resp_active = 1'b1;
            resp_k      = 0;
            req_addr    = mem_addr;
            req_cyc     = cyc;
            req_count++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One client request starting at the current negedge. flush_at/busy_at are
    // cycle offsets from the request cycle for an extra FLUSH or cl_req pulse.
    task automatic do_req(input string name, input logic [24:1] addr, input bit exp_hit,
                          input logic [63:0] exp_data, input int d, input int flush_at,
                          input int busy_at, input logic [24:1] busy_addr);
        int start;
        int rc0;
        int lat;
        resp_delay = d;
        rc0        = req_count;
        start      = cyc;
        lat        = -1;
        cl_req     = 1'b1;
        cl_addr    = addr;
        flush      = (flush_at == 0);
        for (int o = 1; o <= 40; o++) begin
            @(negedge clk);
            if (o == 1) chk({name, "_rdy_low"}, 64'(cl_rdy), 64'd0);
            if (cl_rdy) begin
                lat = o;
                break;
            end
            cl_req  = (busy_at == o);
            cl_addr = (busy_at == o) ? busy_addr : addr;
            flush   = (flush_at == o);
        end
        cl_req  = 1'b0;
        flush   = 1'b0;
        cl_addr = addr;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no cl_rdy expected cl_rdy within 40 cycles", name);
            return;
        end
        chk({name, "_latency"}, 64'(lat), exp_hit ? 64'd2 : 64'(3 + d));
        chk({name, "_data"}, cl_data, exp_data);
        chk({name, "_mem_reqs"}, 64'(req_count - rc0), exp_hit ? 64'd0 : 64'd1);
        if (!exp_hit) begin
            chk({name, "_req_cycle"}, 64'(req_cyc - start), 64'd2);
            chk({name, "_mem_addr"}, 64'(req_addr), 64'(addr));
        end
    endtask

    // Cache model: index -> full address of the resident line.
    logic [24:1] cached [int];

    function automatic void model_note(input logic [24:1] addr, input bit hit,
                                       input int flush_at, input int d);
        int idx;
        idx = int'(addr[10:3]);
        if (!hit) begin
            if (flush_at >= 2 && flush_at <= 2 + d) cached.delete();
            else cached[idx] = addr;
        end
    endfunction

    task automatic model_req(input string name, input logic [24:1] addr, input int d,
                             input int flush_at, input int busy_at,
                             input logic [24:1] busy_addr);
        int idx;
        bit hit;
        idx = int'(addr[10:3]);
        if (flush_at == 0 || flush_at == 1) cached.delete();
        hit = cached.exists(idx) && (cached[idx] == addr);
        do_req(name, addr, hit, mem_word(addr), d, flush_at, busy_at, busy_addr);
        model_note(addr, hit, flush_at, d);
    endtask

    typedef struct {
        logic [24:1] addr;
        bit          flush_first;
        bit          exp_hit;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [13:0] tags [3];
        logic [7:0]  idxs [4];
        int          rc0;
        tags = '{14'h200, 14'h201, 14'h3FF};
        idxs = '{8'd8, 8'd9, 8'd10, 8'd77};

        vecs[0] = '{24'h100040, 1'b1, 1'b0, 64'hDEADBEEF01234567};
        vecs[1] = '{24'h100040, 1'b0, 1'b1, 64'hDEADBEEF01234567};
        vecs[2] = '{24'h200040, 1'b0, 1'b0, mem_word(24'h200040)};
        vecs[3] = '{24'h100040, 1'b0, 1'b0, 64'hDEADBEEF01234567};
        vecs[4] = '{24'h100040, 1'b0, 1'b1, 64'hDEADBEEF01234567};
        vecs[5] = '{24'h100040, 1'b1, 1'b0, 64'hDEADBEEF01234567};
        vecs[6] = '{24'h100040, 1'b0, 1'b1, 64'hDEADBEEF01234567};
        vecs[7] = '{24'h100048, 1'b0, 1'b0, mem_word(24'h100048)};
        vecs[8] = '{24'h100040, 1'b0, 1'b1, 64'hDEADBEEF01234567};
        vecs[9] = '{24'h100048, 1'b0, 1'b1, mem_word(24'h100048)};

        rst_n    = 1'b0;
        flush    = 1'b0;
        cl_req   = 1'b0;
        cl_addr  = '0;
        mem_rdy  = 1'b0;
        mem_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_cl_rdy", 64'(cl_rdy), 64'd1);
        chk("reset_cl_data", cl_data, 64'd0);
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: cold miss, hit, conflict, flush.
        for (int i = 0; i < 10; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data,
                   3 + (i % 4), vecs[i].flush_first ? 0 : -1, -1, '0);
            model_note(vecs[i].addr, vecs[i].exp_hit, -1, 3);
            if (vecs[i].flush_first) cached.delete();
            if (vecs[i].flush_first) cached[int'(vecs[i].addr[10:3])] = vecs[i].addr;
        end

        // Flush mid-fill: data returned, line left invalid.
        model_req("flush_mid", 24'h200040, 5, 4, -1, '0);
        model_req("flush_mid_again", 24'h200040, 3, -1, -1, '0);
        model_req("flush_mid_hit", 24'h200040, 3, -1, -1, '0);
        // Flush in the fill completion cycle.
        model_req("flush_done", 24'h100040, 4, 6, -1, '0);
        model_req("flush_done_again", 24'h100040, 3, -1, -1, '0);
        // Flush during lookup forces a miss on a resident line.
        model_req("flush_lookup", 24'h100040, 3, 1, -1, '0);
        model_req("flush_lookup_hit", 24'h100040, 3, -1, -1, '0);
        // Second request while filling is dropped.
        model_req("busy_drop", 24'h100050, 6, -1, 4, 24'h100048);
        model_req("busy_drop_hit", 24'h100050, 3, -1, -1, '0);

        // Reset in the middle of a fill, late mem_rdy afterwards.
        rc0        = req_count;
        resp_delay = 6;
        cl_req     = 1'b1;
        cl_addr    = 24'h100058;
        for (int o = 0; o < 10 && req_count == rc0; o++) begin
            @(negedge clk);
            cl_req = 1'b0;
        end
        chk("rst_fill_req_seen", 64'(req_count - rc0), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fill_rdy", 64'(cl_rdy), 64'd1);
        chk("rst_fill_data", cl_data, 64'd0);
        repeat (6) @(negedge clk);
        chk("rst_late_rdy", 64'(cl_rdy), 64'd1);
        chk("rst_late_data", cl_data, 64'd0);
        chk("rst_late_reqs", 64'(req_count - rc0), 64'd1);
        cached.delete();
        model_req("rst_after_miss", 24'h100058, 3, -1, -1, '0);
        model_req("rst_after_hit", 24'h100058, 3, -1, -1, '0);
        model_req("rst_other_miss", 24'h100040, 4, -1, -1, '0);

        // Randomized requests against the model.
        for (int i = 0; i < 150; i++) begin
            logic [24:1] a;
            int          d;
            int          fa;
            int          ba;
            int          r;
            a  = {tags[$urandom_range(2, 0)], idxs[$urandom_range(3, 0)], 2'b00};
            d  = int'($urandom_range(6, 3));
            r  = int'($urandom_range(9, 0));
            fa = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? int'($urandom_range(2 + d, 2)) : -1;
            ba = ($urandom_range(9, 0) == 0) ? int'($urandom_range(1 + d, 1)) : -1;
            model_req($sformatf("rnd%0d", i), a, d, fa, ba,
                      {tags[$urandom_range(2, 0)], idxs[$urandom_range(3, 0)], 2'b00});
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
